// File: rtl/rv32_pipeline_pkg.sv
// Shared types for the RV32 pipeline stall/flush scheduler: FSM states,
// the drain/flush counter width and the debug cause encoding.
package rv32_pipeline_pkg;

    localparam int unsigned CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        TRAP_FLUSH
    } state_e;

    // Winning request of the current cycle, in priority order TRAP highest.
    typedef enum logic [2:0] {
        NONE,
        LOADUSE,
        MEMBUSY,
        MISPRED,
        FENCE,
        TRAP
    } cause_e;

endpackage

// File: rtl/rv32_hazard_detect.sv
// Combinational load-use comparator: a load in execute whose destination
// is read by the valid instruction sitting in decode.
module rv32_hazard_detect (
    input  logic       decode_valid_in,
    input  logic [4:0] rs1_in,
    input  logic       rs1_read_in,
    input  logic [4:0] rs2_in,
    input  logic       rs2_read_in,
    input  logic       ex_valid_in,
    input  logic       ex_mem_read_in,
    input  logic [4:0] ex_rd_in,
    input  logic       ex_rd_write_in,
    output logic       load_use_out
);

    logic ex_load_writes;
    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        ex_load_writes = ex_valid_in && ex_mem_read_in && ex_rd_write_in && (ex_rd_in != '0);
        rs1_hit        = rs1_read_in && (rs1_in == ex_rd_in);
        rs2_hit        = rs2_read_in && (rs2_in == ex_rd_in);
        load_use_out   = decode_valid_in && ex_load_writes && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/rv32_pipeline_ctrl.sv
// Central stall/flush scheduler for the five-stage RV32 pipeline: load-use
// stalls, memory back-pressure, FENCE drains and mispredict/trap flushes.
module rv32_pipeline_ctrl
    import rv32_pipeline_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES      = 3,
    parameter int unsigned TRAP_FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_i,
    input  logic        decode_valid_in,
    input  logic [4:0]  rs1_unreg_in,
    input  logic        rs1_read_unreg_in,
    input  logic [4:0]  rs2_unreg_in,
    input  logic        rs2_read_unreg_in,
    input  logic        mem_fence_unreg_in,
    input  logic        ex_valid_in,
    input  logic        ex_mem_read_in,
    input  logic [4:0]  ex_rd_in,
    input  logic        ex_rd_write_in,
    input  logic        ex_mispredict_in,
    input  logic        mem_busy_in,
    input  logic        wb_trap_in,
    output logic        fetch_stall_out,
    output logic        decode_stall_out,
    output logic        decode_flush_out,
    output logic        execute_stall_out,
    output logic        execute_flush_out,
    output logic        mem_stall_out,
    output logic        mem_flush_out,
    output logic        writeback_flush_out,
    output logic        busy_out,
    output logic [31:0] stall_count_out
);

    localparam cnt_t DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);
    localparam cnt_t TRAP_LOAD  = CNT_W'(TRAP_FLUSH_CYCLES);

    state_e      state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic        fence_done_q, fence_done_d;
    logic [31:0] stall_count_q, stall_count_d;

    logic   load_use;
    logic   fence_req;
    cause_e cause;

    rv32_hazard_detect u_hazard (
        .decode_valid_in (decode_valid_in),
        .rs1_in          (rs1_unreg_in),
        .rs1_read_in     (rs1_read_unreg_in),
        .rs2_in          (rs2_unreg_in),
        .rs2_read_in     (rs2_read_unreg_in),
        .ex_valid_in     (ex_valid_in),
        .ex_mem_read_in  (ex_mem_read_in),
        .ex_rd_in        (ex_rd_in),
        .ex_rd_write_in  (ex_rd_write_in),
        .load_use_out    (load_use)
    );

    // The TRAP_FLUSH state owns the cycle unless a new trap arrives, so it
    // maps to NONE here and its flushes are added from the state below.
    always_comb begin
        fence_req = (state_q == RUN) && decode_valid_in && mem_fence_unreg_in && !fence_done_q;
        cause     = NONE;
        if (wb_trap_in)                                cause = TRAP;
        else if (state_q == TRAP_FLUSH)                cause = NONE;
        else if (mem_busy_in)                          cause = MEMBUSY;
        else if (state_q == RUN && ex_mispredict_in)   cause = MISPRED;
        else if (state_q == DRAIN || fence_req)        cause = FENCE;
        else if (load_use)                             cause = LOADUSE;
    end

    always_comb begin
        fetch_stall_out     = 1'b0;
        decode_stall_out    = 1'b0;
        decode_flush_out    = 1'b0;
        execute_stall_out   = 1'b0;
        execute_flush_out   = 1'b0;
        mem_stall_out       = 1'b0;
        mem_flush_out       = 1'b0;
        writeback_flush_out = 1'b0;
        busy_out            = (state_q != RUN);

        unique case (cause)
            TRAP: begin
                decode_flush_out    = 1'b1;
                execute_flush_out   = 1'b1;
                mem_flush_out       = 1'b1;
                writeback_flush_out = 1'b1;
            end
            MEMBUSY: begin
                fetch_stall_out     = 1'b1;
                decode_stall_out    = 1'b1;
                execute_stall_out   = 1'b1;
                mem_stall_out       = 1'b1;
                writeback_flush_out = 1'b1;
            end
            MISPRED: begin
                decode_flush_out  = 1'b1;
                execute_flush_out = 1'b1;
            end
            // The entry cycle also holds decode so the FENCE cannot slip
            // into execute before the drain starts.
            FENCE, LOADUSE: begin
                fetch_stall_out   = 1'b1;
                decode_stall_out  = 1'b1;
                execute_flush_out = 1'b1;
            end
            default: begin
                if (state_q == TRAP_FLUSH) begin
                    decode_flush_out  = 1'b1;
                    execute_flush_out = 1'b1;
                    mem_flush_out     = 1'b1;
                end
            end
        endcase

        if (reset) begin
            fetch_stall_out     = 1'b0;
            decode_stall_out    = 1'b0;
            decode_flush_out    = 1'b0;
            execute_stall_out   = 1'b0;
            execute_flush_out   = 1'b0;
            mem_stall_out       = 1'b0;
            mem_flush_out       = 1'b0;
            writeback_flush_out = 1'b0;
            busy_out            = 1'b0;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        fence_done_d  = fence_done_q;
        stall_count_d = stall_count_q + 32'(decode_stall_out);

        if (!decode_stall_out) fence_done_d = 1'b0;

        unique case (cause)
            TRAP: begin
                state_d      = TRAP_FLUSH;
                cnt_d        = TRAP_LOAD;
                fence_done_d = 1'b0;
            end
            FENCE: begin
                if (state_q == RUN) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end else if (cnt_q <= cnt_t'(1)) begin
                    state_d      = RUN;
                    cnt_d        = '0;
                    fence_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            default: begin
                if (state_q == TRAP_FLUSH) begin
                    if (cnt_q <= cnt_t'(1)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - cnt_t'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            fence_done_q  <= 1'b0;
            stall_count_q <= '0;
        end else if (ce_i) begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fence_done_q  <= fence_done_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count_out = stall_count_q;

endmodule

// File: tb/tb_rv32_pipeline_ctrl.sv
// Self-checking bench for rv32_pipeline_ctrl: a table of single-cycle
// patterns plus hand-written multi-cycle sequences, checked via a queue.
module tb_rv32_pipeline_ctrl;

    typedef struct packed {
        logic       ce;
        logic       dv;
        logic [4:0] rs1;
        logic       r1;
        logic [4:0] rs2;
        logic       r2;
        logic       fence;
        logic       exv;
        logic       exmr;
        logic [4:0] exrd;
        logic       exw;
        logic       misp;
        logic       busy;
        logic       trap;
    } in_t;

    typedef struct {
        in_t        in;
        logic [8:0] exp;
        string      name;
    } vec_t;

    // Output order: fetch_stall, decode_stall, decode_flush, ex_stall,
    // ex_flush, mem_stall, mem_flush, wb_flush, busy.
    localparam logic [8:0] O_NONE  = 9'b000000000;
    localparam logic [8:0] O_LU    = 9'b110010000;
    localparam logic [8:0] O_FENT  = 9'b110010000;
    localparam logic [8:0] O_DRAIN = 9'b110010001;
    localparam logic [8:0] O_BUSY  = 9'b110101010;
    localparam logic [8:0] O_BUSYD = 9'b110101011;
    localparam logic [8:0] O_MISP  = 9'b001010000;
    localparam logic [8:0] O_TRAP  = 9'b001010110;
    localparam logic [8:0] O_TRAPB = 9'b001010111;
    localparam logic [8:0] O_TF    = 9'b001010101;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce_i;
    logic        decode_valid_in;
    logic [4:0]  rs1_unreg_in;
    logic        rs1_read_unreg_in;
    logic [4:0]  rs2_unreg_in;
    logic        rs2_read_unreg_in;
    logic        mem_fence_unreg_in;
    logic        ex_valid_in;
    logic        ex_mem_read_in;
    logic [4:0]  ex_rd_in;
    logic        ex_rd_write_in;
    logic        ex_mispredict_in;
    logic        mem_busy_in;
    logic        wb_trap_in;
    logic        fetch_stall_out;
    logic        decode_stall_out;
    logic        decode_flush_out;
    logic        execute_stall_out;
    logic        execute_flush_out;
    logic        mem_stall_out;
    logic        mem_flush_out;
    logic        writeback_flush_out;
    logic        busy_out;
    logic [31:0] stall_count_out;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_count = '0;
    logic [8:0]  exp_q[$];
    string       name_q[$];
    vec_t        tbl[$];

    always #5 clk = ~clk;

    rv32_pipeline_ctrl #(
        .DRAIN_CYCLES      (3),
        .TRAP_FLUSH_CYCLES (2)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .ce_i                (ce_i),
        .decode_valid_in     (decode_valid_in),
        .rs1_unreg_in        (rs1_unreg_in),
        .rs1_read_unreg_in   (rs1_read_unreg_in),
        .rs2_unreg_in        (rs2_unreg_in),
        .rs2_read_unreg_in   (rs2_read_unreg_in),
        .mem_fence_unreg_in  (mem_fence_unreg_in),
        .ex_valid_in         (ex_valid_in),
        .ex_mem_read_in      (ex_mem_read_in),
        .ex_rd_in            (ex_rd_in),
        .ex_rd_write_in      (ex_rd_write_in),
        .ex_mispredict_in    (ex_mispredict_in),
        .mem_busy_in         (mem_busy_in),
        .wb_trap_in          (wb_trap_in),
        .fetch_stall_out     (fetch_stall_out),
        .decode_stall_out    (decode_stall_out),
        .decode_flush_out    (decode_flush_out),
        .execute_stall_out   (execute_stall_out),
        .execute_flush_out   (execute_flush_out),
        .mem_stall_out       (mem_stall_out),
        .mem_flush_out       (mem_flush_out),
        .writeback_flush_out (writeback_flush_out),
        .busy_out            (busy_out),
        .stall_count_out     (stall_count_out)
    );

    function automatic in_t mk_idle();
        in_t v;
        v    = '0;
        v.ce = 1'b1;
        return v;
    endfunction

    // lw to x<rd> in execute; decode reads rs1=x1, rs2=x5.
    function automatic in_t mk_lu(input logic [4:0] rd);
        in_t v;
        v      = mk_idle();
        v.dv   = 1'b1;
        v.rs1  = 5'd1;
        v.r1   = 1'b1;
        v.rs2  = 5'd5;
        v.r2   = 1'b1;
        v.exv  = 1'b1;
        v.exmr = 1'b1;
        v.exrd = rd;
        v.exw  = 1'b1;
        return v;
    endfunction

    function automatic in_t mk_fence();
        in_t v;
        v       = mk_idle();
        v.dv    = 1'b1;
        v.fence = 1'b1;
        return v;
    endfunction

    function automatic vec_t mkv(input in_t v, input logic [8:0] e, input string nm);
        vec_t r;
        r.in   = v;
        r.exp  = e;
        r.name = nm;
        return r;
    endfunction

    task automatic apply(input in_t v);
        ce_i               = v.ce;
        decode_valid_in    = v.dv;
        rs1_unreg_in       = v.rs1;
        rs1_read_unreg_in  = v.r1;
        rs2_unreg_in       = v.rs2;
        rs2_read_unreg_in  = v.r2;
        mem_fence_unreg_in = v.fence;
        ex_valid_in        = v.exv;
        ex_mem_read_in     = v.exmr;
        ex_rd_in           = v.exrd;
        ex_rd_write_in     = v.exw;
        ex_mispredict_in   = v.misp;
        mem_busy_in        = v.busy;
        wb_trap_in         = v.trap;
    endtask

    task automatic check_outputs();
        logic [8:0] act;
        logic [8:0] e;
        string      nm;
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {fetch_stall_out, decode_stall_out, decode_flush_out,
               execute_stall_out, execute_flush_out, mem_stall_out,
               mem_flush_out, writeback_flush_out, busy_out};
        checks++;
        if (act !== e) begin
            failures++;
            $display("FAIL %s: outputs=%b expected=%b", nm, act, e);
        end
    endtask

    task automatic step(input in_t v, input logic [8:0] e, input string nm);
        @(negedge clk);
        apply(v);
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (e[7] && v.ce && !reset) exp_count = exp_count + 32'd1;
        #2;
        check_outputs();
    endtask

    task automatic check_count(input string nm);
        @(posedge clk);
        #1;
        checks++;
        if (stall_count_out !== exp_count) begin
            failures++;
            $display("FAIL %s: stall_count=%h expected=%h", nm, stall_count_out, exp_count);
        end
    endtask

    initial begin
        in_t v;
        reset = 1'b1;
        apply(mk_idle());

        step(mk_lu(5'd5), O_NONE, "reset_lu_masked");
        step(mk_fence(), O_NONE, "reset_fence_masked");
        check_count("reset_count");
        reset = 1'b0;

        tbl.push_back(mkv(mk_lu(5'd5), O_LU, "lu_rs2"));
        tbl.push_back(mkv(mk_lu(5'd1), O_LU, "lu_rs1"));
        v = mk_lu(5'd0); v.rs1 = 5'd0; v.rs2 = 5'd0;
        tbl.push_back(mkv(v, O_NONE, "lu_rd_x0"));
        v = mk_lu(5'd5); v.exmr = 1'b0;
        tbl.push_back(mkv(v, O_NONE, "not_load"));
        v = mk_lu(5'd5); v.exw = 1'b0;
        tbl.push_back(mkv(v, O_NONE, "no_rd_write"));
        v = mk_lu(5'd5); v.exv = 1'b0;
        tbl.push_back(mkv(v, O_NONE, "ex_invalid"));
        v = mk_lu(5'd5); v.dv = 1'b0;
        tbl.push_back(mkv(v, O_NONE, "dec_invalid"));
        v = mk_lu(5'd5); v.r2 = 1'b0;
        tbl.push_back(mkv(v, O_NONE, "rs2_unread"));
        tbl.push_back(mkv(mk_lu(5'd7), O_NONE, "no_match"));
        v = mk_idle(); v.misp = 1'b1;
        tbl.push_back(mkv(v, O_MISP, "misp"));
        v = mk_lu(5'd5); v.misp = 1'b1;
        tbl.push_back(mkv(v, O_MISP, "misp_over_lu"));
        v = mk_lu(5'd5); v.misp = 1'b1; v.busy = 1'b1;
        tbl.push_back(mkv(v, O_BUSY, "busy_over_misp"));
        v = mk_idle(); v.busy = 1'b1;
        tbl.push_back(mkv(v, O_BUSY, "busy"));
        tbl.push_back(mkv(mk_idle(), O_NONE, "idle"));

        foreach (tbl[i]) step(tbl[i].in, tbl[i].exp, tbl[i].name);
        check_count("table_count");

        // FENCE drain: entry, three DRAIN cycles, then the fence passes.
        step(mk_fence(), O_FENT, "fence_entry");
        for (int i = 0; i < 3; i++) step(mk_fence(), O_DRAIN, "fence_drain");
        step(mk_fence(), O_NONE, "fence_pass");
        step(mk_idle(), O_NONE, "fence_after");

        // Drain stretched by two busy cycles.
        step(mk_fence(), O_FENT, "fb_entry");
        step(mk_fence(), O_DRAIN, "fb_drain1");
        v = mk_fence(); v.busy = 1'b1;
        step(v, O_BUSYD, "fb_busy1");
        step(v, O_BUSYD, "fb_busy2");
        step(mk_fence(), O_DRAIN, "fb_drain2");
        step(mk_fence(), O_DRAIN, "fb_drain3");
        step(mk_fence(), O_NONE, "fb_pass");
        check_count("fence_count");

        // Trap aborts a drain; fence drains again afterwards.
        step(mk_fence(), O_FENT, "ft_entry");
        step(mk_fence(), O_DRAIN, "ft_drain1");
        v = mk_fence(); v.trap = 1'b1;
        step(v, O_TRAPB, "ft_trap");
        step(mk_idle(), O_TF, "ft_tf1");
        step(mk_idle(), O_TF, "ft_tf2");
        step(mk_fence(), O_FENT, "ft_reentry");
        for (int i = 0; i < 3; i++) step(mk_fence(), O_DRAIN, "ft_redrain");
        step(mk_fence(), O_NONE, "ft_pass");

        // Trap beats busy; a second trap reloads the flush counter.
        v = mk_idle(); v.trap = 1'b1; v.busy = 1'b1;
        step(v, O_TRAP, "trap_busy");
        step(mk_idle(), O_TF, "tr_tf1");
        v = mk_idle(); v.trap = 1'b1;
        step(v, O_TRAPB, "tr_reload");
        step(mk_idle(), O_TF, "tr_tf2");
        step(mk_idle(), O_TF, "tr_tf3");
        step(mk_idle(), O_NONE, "tr_run");

        // ce_i low holds state and counter.
        v = mk_fence(); v.ce = 1'b0;
        step(v, O_FENT, "ce_run_hold");
        step(mk_fence(), O_FENT, "ce_entry");
        step(mk_fence(), O_DRAIN, "ce_drain1");
        step(v, O_DRAIN, "ce_hold1");
        step(v, O_DRAIN, "ce_hold2");
        step(mk_fence(), O_DRAIN, "ce_drain2");
        step(mk_fence(), O_DRAIN, "ce_drain3");
        step(mk_fence(), O_NONE, "ce_pass");
        check_count("ce_count");

        // Counter wrap.
        dut.stall_count_q = 32'hFFFF_FFFE;
        exp_count         = 32'hFFFF_FFFE;
        step(mk_lu(5'd5), O_LU, "wrap_lu1");
        check_count("wrap_ffffffff");
        step(mk_lu(5'd5), O_LU, "wrap_lu2");
        check_count("wrap_zero");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rv32_pipeline_ctrl.md
Name: rv32_pipeline_ctrl

Overview:
Central stall/flush scheduler for the five-stage RV32 pipeline: fetch, decode, execute, memory, writeback. It resolves load-use hazards and memory back-pressure. It sequences FENCE drains and branch-mispredict/trap flushes using a small FSM. It drives the stall_in, flush_in and writeback_flush_in controls of every stage register bank, and keeps a decode-stall performance counter.

Parameters:
DRAIN_CYCLES, 3, cycles of bubbles inserted behind a FENCE so the execute, memory and writeback stages empty (1..15).
TRAP_FLUSH_CYCLES, 2, cycles decode/execute/memory stay flushed after a trap or mret redirect (1..15).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ce_i  in  1  clock enable; state and counters advance only when high
decode_valid_in  in  1  decode holds a valid instruction
rs1_unreg_in  in  5  decode rs1 index (unregistered)
rs1_read_unreg_in  in  1  decode reads rs1
rs2_unreg_in  in  5  decode rs2 index
rs2_read_unreg_in  in  1  decode reads rs2
mem_fence_unreg_in  in  1  decode instruction is FENCE/FENCE.I
ex_valid_in  in  1  execute stage valid
ex_mem_read_in  in  1  execute instruction is a load
ex_rd_in  in  5  execute destination
ex_rd_write_in  in  1  execute writes rd
ex_mispredict_in  in  1  execute resolved a mispredicted branch/jump
mem_busy_in  in  1  memory stage waiting on bus
wb_trap_in  in  1  writeback takes exception/interrupt or retires mret
fetch_stall_out  out  1  hold fetch
decode_stall_out  out  1  hold decode register bank
decode_flush_out  out  1  bubble into decode output
execute_stall_out  out  1  hold execute
execute_flush_out  out  1  bubble into execute output
mem_stall_out  out  1  hold memory stage
mem_flush_out  out  1  bubble into memory output
writeback_flush_out  out  1  suppress register write/retire in writeback
busy_out  out  1  FSM not in RUN
stall_count_out  out  32  decode-stall cycle counter

Behaviour:
- Reset: state RUN, drain/flush counter 0, fence_done 0, stall_count_out 0. While reset is high all stall/flush outputs and busy_out are 0.
- FSM states: RUN, DRAIN, TRAP_FLUSH. Transitions occur only on ce_i-high edges. With ce_i low, state and counters hold; outputs stay combinational from current state and inputs.
- Load-use hazard: ex_valid & ex_mem_read & ex_rd_write & ex_rd!=0 & ((rs1_read & rs1==ex_rd) | (rs2_read & rs2==ex_rd)) & decode_valid.
  - Same cycle: fetch_stall, decode_stall and execute_flush are asserted. Zero latency, no state.
- mem_busy_in (RUN or DRAIN): fetch, decode, execute and mem stall; writeback_flush=1. DRAIN counter does not decrement.
- ex_mispredict_in (RUN): decode_flush and execute_flush for exactly that cycle. Overrides load-use. Ignored if mem_busy_in is also high; execute holds and the mispredict is retried next cycle.
- FENCE entry: in RUN with decode_valid & mem_fence_unreg & !fence_done, go to DRAIN and set counter=DRAIN_CYCLES.
  - In DRAIN: fetch_stall, decode_stall and execute_flush asserted. Counter decrements per enabled non-busy cycle.
  - At counter reaching 0: go to RUN and set fence_done=1, so the fence advances the next cycle without re-entering DRAIN.
  - fence_done clears on any enabled cycle with decode_stall low.
- wb_trap_in has highest priority in any state, even with mem_busy_in.
  - Same cycle: decode_flush, execute_flush, mem_flush and writeback_flush asserted; fetch not stalled.
  - Next state TRAP_FLUSH with counter=TRAP_FLUSH_CYCLES. An in-progress DRAIN is aborted and fence_done cleared.
- TRAP_FLUSH: decode, execute and mem flush each cycle; counter decrements; at 0 go to RUN. A wb_trap_in arriving during TRAP_FLUSH reloads the counter.
- Priority: trap > mem_busy > mispredict > DRAIN/fence entry > load-use.
- Stall and flush may both be high for a stage; stall wins (register holds).
- stall_count_out: +1 on every ce_i cycle with decode_stall_out=1. Wraps 0xFFFFFFFF -> 0.

Decomposition:
- Shared package rv32_pipeline_pkg holds the FSM state enum (RUN, DRAIN, TRAP_FLUSH), the 4-bit counter width constant, and the priority-encoded cause enum (NONE, LOADUSE, MEMBUSY, MISPRED, FENCE, TRAP) for debug.
- Sub-module rv32_hazard_detect: purely combinational load-use comparator, reused by formal checks.

Test Plan:
1. lw x5 in execute, decode add reads rs2=x5 -> one cycle fetch/decode stall + execute_flush; same with rd=x0 -> no stall.
2. FENCE in decode, DRAIN_CYCLES=3 -> exactly 3 stall cycles, busy_out high 3 cycles, fence passes on 4th cycle, no re-entry.
3. FENCE drain with mem_busy_in high for 2 cycles mid-drain -> drain lasts 5 cycles total; writeback_flush high during busy.
4. wb_trap_in during DRAIN cycle 2 -> all flushes same cycle, TRAP_FLUSH for 2 cycles, RUN; fence re-drains when it re-enters decode.
5. ex_mispredict_in together with a load-use hazard -> only decode/execute flush, no stall; with mem_busy_in -> stalls only.
6. Force stall_count to 0xFFFFFFFE, two stall cycles -> 0xFFFFFFFF then 0x00000000; ce_i low -> counter and state hold.
